regfile_wb_ctrl: RTL

//  - Write-side driver for the 2-entry, 4-bit CPU register file (R0/R1).
//  - Takes ALU/load results over a valid/ready handshake and queues them.
//  - Issues at most one write per cycle on the register file's data_in / write_en / select_line.
//  - Exports per-register pending flags so decode can stall read-after-write hazards.

---
 rtl/regwb_pkg.sv | 22 ++
 rtl/regwb_fifo.sv | 80 ++++++++
 rtl/regfile_wb_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/regwb_pkg.sv
// Shared types for the register-file write-back controller: register index,
// FSM state encoding and the queued write entry.
package regwb_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int NUM_REGS   = 2;
    localparam int REG_IDX_W  = $clog2(NUM_REGS);

    typedef logic [REG_IDX_W-1:0] regIdx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STALL
    } wbState_t;

    typedef struct packed {
        regIdx_t               dest;
        logic [DEF_DATA_W-1:0] data;
    } wbEntry_t;

endpackage

// File: rtl/regwb_fifo.sv
// Circular buffer of pending register writes with per-entry valid/dest export.
// With WB_COALESCE_EN defined it can also overwrite the youngest entry's data.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  wbEntry_t                 i_pushEntry,
`ifdef WB_COALESCE_EN
    input  logic                     i_coalesce,
    output regIdx_t                  o_youngestDest,
`endif
    output wbEntry_t                 o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [DEPTH-1:0]         o_valid,
    output regIdx_t [DEPTH-1:0]      o_dest
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    wbEntry_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic [DEPTH-1:0] r_valid;

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] w_youngestPtr;
    assign w_youngestPtr  = r_wrPtr - PTR_ONE;
    assign o_youngestDest = r_mem[w_youngestPtr].dest;
`endif

    // The pop clear comes before the push set so a full push+pop on the same slot keeps it valid.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (i_pop) begin
                r_valid[r_rdPtr] <= 1'b0;
                r_rdPtr          <= r_rdPtr + PTR_ONE;
            end
`ifdef WB_COALESCE_EN
            if (i_coalesce) begin
                r_mem[w_youngestPtr].data <= i_pushEntry.data;
            end
`endif
            if (i_push) begin
                r_mem[r_wrPtr]   <= i_pushEntry;
                r_valid[r_wrPtr] <= 1'b1;
                r_wrPtr          <= r_wrPtr + PTR_ONE;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_dest[i] = r_mem[i].dest;
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_valid = r_valid;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-side driver for the R0/R1 register file: queues write-backs, issues one per cycle.
// Optional WB_COALESCE_EN merges a push into the youngest queued entry with the same dest.
module regfile_wb_ctrl
    import regwb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic                wb_dest,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                hold,
    input  logic                flush,
    output logic                write_en,
    output logic                select_line,
    output logic [DATA_W-1:0]   data_in,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    wr_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [CNT_W-1:0] WR_ONE   = CNT_W'(1);

    wbState_t          r_state;
    logic              r_writeEn;
    regIdx_t           r_selectLine;
    logic [DATA_W-1:0] r_dataIn;
    logic [CNT_W-1:0]  r_wrCount;

    wbEntry_t             w_head;
    wbEntry_t             w_pushEntry;
    logic [PTR_W:0]       w_count;
    logic [PTR_W:0]       w_nextCount;
    logic [DEPTH-1:0]     w_valid;
    regIdx_t [DEPTH-1:0]  w_dest;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_coalesceHit;
    logic [NUM_REGS-1:0]  w_pending;

    // Non-IDLE always means the queue holds something, so the state alone gates issue.
    assign w_pop = (r_state != ST_IDLE) && !hold && !flush;

`ifdef WB_COALESCE_EN
    regIdx_t w_youngestDest;
    // Never merge into an entry that is leaving the queue this same cycle.
    assign w_coalesceHit = (w_count != '0) && (w_youngestDest == wb_dest)
                           && !(w_pop && (w_count == CNT_ONE));
`else
    assign w_coalesceHit = 1'b0;
`endif

    assign wb_ready    = !reset && ((w_count < FULL_CNT) || w_pop || w_coalesceHit);
    assign w_accept    = wb_valid && wb_ready && !flush;
    assign w_push      = w_accept && !w_coalesceHit;
    assign w_pushEntry = {wb_dest, wb_data};

    regwb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .i_push         (w_push),
        .i_pop          (w_pop),
        .i_flush        (flush),
        .i_pushEntry    (w_pushEntry),
`ifdef WB_COALESCE_EN
        .i_coalesce     (w_accept && w_coalesceHit),
        .o_youngestDest (w_youngestDest),
`endif
        .o_head         (w_head),
        .o_count        (w_count),
        .o_valid        (w_valid),
        .o_dest         (w_dest)
    );

    always_comb begin
        w_nextCount = w_count;
        if (w_push && !w_pop) begin
            w_nextCount = w_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_nextCount = w_count - CNT_ONE;
        end
    end

    // FSM and registered register-file interface; select_line/data_in hold between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_writeEn    <= 1'b0;
            r_selectLine <= '0;
            r_dataIn     <= '0;
            r_wrCount    <= '0;
        end else begin
            r_writeEn <= w_pop;
            if (w_pop) begin
                r_selectLine <= w_head.dest;
                r_dataIn     <= w_head.data;
                r_wrCount    <= r_wrCount + WR_ONE;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_push) r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (flush || w_nextCount == '0) r_state <= ST_IDLE;
                    else if (hold)                  r_state <= ST_STALL;
                end
                ST_STALL: begin
                    if (flush || w_nextCount == '0) r_state <= ST_IDLE;
                    else if (!hold)                 r_state <= ST_ISSUE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) w_pending[w_dest[i]] = 1'b1;
        end
        if (r_writeEn) w_pending[r_selectLine] = 1'b1;
    end

    assign write_en    = r_writeEn;
    assign select_line = r_selectLine;
    assign data_in     = r_dataIn;
    assign pending     = w_pending;
    assign wr_count    = r_wrCount;

endmodule
